// File: rtl/regfile_dbg_if.sv
// Debug-port bundle for regfile_dbg: command channel, response channel and
// the register-file write/read port the block drives while busy.
interface regfile_dbg_if #(
    parameter int AW = 3,
    parameter int DW = 4
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;

    logic          rf_we;
    logic [AW-1:0] rf_rd_addr;
    logic [DW-1:0] rf_rd_data;
    logic [AW-1:0] rf_rs1_addr;
    logic [DW-1:0] rf_rs1_data;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data;
    logic          rsp_last;
    logic          rsp_err;

    logic          busy;

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, rf_rs1_data, rsp_ready,
        output cmd_ready, rf_we, rf_rd_addr, rf_rd_data, rf_rs1_addr,
               rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err, busy
    );

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, rf_rs1_data, rsp_ready,
        input  cmd_ready, rf_we, rf_rd_addr, rf_rd_data, rf_rs1_addr,
               rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err, busy
    );
endinterface

// File: rtl/regfile_dbg.sv
// Register-file debug port: READ/WRITE single registers, DUMP x0..x7 as a
// response stream, CLEAR x1..x7. x0 is never written.
module regfile_dbg #(
    parameter int AW = 3,
    parameter int DW = 4
) (
    input logic         clk,
    input logic         rst,
    regfile_dbg_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_CLR, S_RSP} state_t;
    typedef enum logic [1:0] {OP_READ = 2'b00, OP_WRITE = 2'b01,
                              OP_DUMP = 2'b10, OP_CLEAR = 2'b11} op_t;

    localparam logic [AW-1:0] ADDR_LAST = '1;
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

    state_t        state, state_nxt;
    op_t           op_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic [AW-1:0] rsp_addr_q;
    logic [DW-1:0] rsp_data_q;
    logic          rsp_last_q, rsp_err_q;

    logic          cmd_ready_c, rf_we_c, rsp_valid_c, accept;
    logic [AW-1:0] rf_rd_addr_c;
    logic [DW-1:0] rf_rd_data_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // cmd_ready is gated by rst so nothing is offered while reset is held
    always_comb begin
        state_nxt    = state;
        cmd_ready_c  = 1'b0;
        rf_we_c      = 1'b0;
        rf_rd_addr_c = '0;
        rf_rd_data_c = '0;
        rsp_valid_c  = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready_c = rst;
                if (bus.cmd_valid && rst) begin
                    case (op_t'(bus.cmd_op))
                        OP_READ, OP_DUMP: state_nxt = S_RD;
                        OP_WRITE:         state_nxt = S_WR;
                        default:          state_nxt = S_CLR;
                    endcase
                end
            end
            S_RD: state_nxt = S_RSP;
            S_WR: begin
                if (addr_q != '0) begin
                    rf_we_c      = 1'b1;
                    rf_rd_addr_c = addr_q;
                    rf_rd_data_c = data_q;
                end
                state_nxt = S_RSP;
            end
            S_CLR: begin
                rf_we_c      = 1'b1;
                rf_rd_addr_c = addr_q;
                if (addr_q == ADDR_LAST) state_nxt = S_RSP;
            end
            S_RSP: begin
                rsp_valid_c = 1'b1;
                if (bus.rsp_ready) begin
                    if (op_q == OP_DUMP && addr_q != ADDR_LAST) state_nxt = S_RD;
                    else                                        state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign accept = bus.cmd_valid && cmd_ready_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q       <= OP_READ;
            addr_q     <= '0;
            data_q     <= '0;
            rsp_addr_q <= '0;
            rsp_data_q <= '0;
            rsp_last_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q   <= op_t'(bus.cmd_op);
                        data_q <= bus.cmd_data;
                        case (op_t'(bus.cmd_op))
                            OP_DUMP:  addr_q <= '0;
                            OP_CLEAR: addr_q <= ADDR_ONE;
                            default:  addr_q <= bus.cmd_addr;
                        endcase
                    end
                end
                S_RD: begin
                    rsp_data_q <= bus.rf_rs1_data;
                    rsp_addr_q <= addr_q;
                    rsp_err_q  <= 1'b0;
                    rsp_last_q <= (op_q != OP_DUMP) || (addr_q == ADDR_LAST);
                end
                S_WR: begin
                    rsp_data_q <= data_q;
                    rsp_addr_q <= addr_q;
                    rsp_err_q  <= (addr_q == '0);
                    rsp_last_q <= 1'b1;
                end
                S_CLR: begin
                    if (addr_q == ADDR_LAST) begin
                        rsp_addr_q <= addr_q;
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b0;
                        rsp_last_q <= 1'b1;
                    end else begin
                        addr_q <= addr_q + ADDR_ONE;
                    end
                end
                S_RSP: begin
                    if (bus.rsp_ready && op_q == OP_DUMP && addr_q != ADDR_LAST)
                        addr_q <= addr_q + ADDR_ONE;
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready   = cmd_ready_c;
    assign bus.busy        = (state != S_IDLE);
    assign bus.rf_we       = rf_we_c;
    assign bus.rf_rd_addr  = rf_rd_addr_c;
    assign bus.rf_rd_data  = rf_rd_data_c;
    assign bus.rf_rs1_addr = addr_q;
    assign bus.rsp_valid   = rsp_valid_c;
    assign bus.rsp_addr    = rsp_addr_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_last    = rsp_last_q;
    assign bus.rsp_err     = rsp_err_q;
endmodule

// File: doc/regfile_dbg.md
REGFILE_DBG -- requirements
Module: regfile_dbg

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst.
REQ-002 Parameter AW, default 3: register address width (2^AW registers, x0..x7).
REQ-003 Parameter DW, default 4: register data width.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-008 cmd_op  input  2  00 READ, 01 WRITE, 10 DUMP (read x0..x7), 11 CLEAR (zero x1..x7).
REQ-009 cmd_addr  input  AW  target register for READ/WRITE; ignored for DUMP/CLEAR.
REQ-010 cmd_data  input  DW  write data for WRITE.
REQ-011 rf_we, rf_rd_addr[AW], rf_rd_data[DW]  outputs  register-file write port.
REQ-012 rf_rs1_addr  output  AW  register-file read address; rf_rs1_data  input  DW  asynchronous read data.
REQ-013 rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-014 rsp_addr[AW], rsp_data[DW], rsp_last 1, rsp_err 1  outputs  response payload.
REQ-015 busy  output  1  high whenever state is not IDLE; the CPU SHALL not drive the register file while busy.

Function
REQ-016 States: IDLE, RD, WR, CLR, RSP.
REQ-017 cmd_ready SHALL equal (state==IDLE) and SHALL be 0 while rst is low.
REQ-018 On accept, the block SHALL latch op, addr, data; READ/DUMP -> RD (DUMP latches addr=0), WRITE -> WR, CLEAR -> CLR (addr=1).
REQ-019 RD (1 cycle): rf_rs1_addr=latched addr; rsp_data<=rf_rs1_data, rsp_addr<=addr; -> RSP.
REQ-020 WR (1 cycle): if addr!=0, rf_we=1, rf_rd_addr=addr, rf_rd_data=data, rsp_err<=0; if addr==0, rf_we=0, rsp_err<=1; rsp_data<=data; -> RSP.
REQ-021 CLR: rf_we=1, rf_rd_data=0, rf_rd_addr=addr, addr increments each cycle for 7 cycles (x1..x7); after addr 7 -> RSP with rsp_addr=7, rsp_data=0.
REQ-022 rf_we SHALL be 0 in every state other than WR (addr!=0) and CLR; rf_we SHALL never be asserted with rf_rd_addr=0.
REQ-023 RSP: rsp_valid=1 with payload stable until rsp_ready sampled high.
REQ-024 rsp_last SHALL be 1 for READ, WRITE, CLEAR responses, and for DUMP only on addr 7.
REQ-025 On RSP handshake: DUMP with addr<7 -> addr+1, RD; otherwise -> IDLE.
REQ-026 Latency: command accepted at edge N -> rsp_valid high after edge N+2 (READ/WRITE), after edge N+8 (CLEAR).
REQ-027 DUMP SHALL emit exactly 8 responses, addr 0..7, each 2 cycles apart when rsp_ready held high; x0 returns the value on rf_rs1_data (0).
REQ-028 Address counter SHALL not wrap: DUMP/CLEAR terminate at addr 7.
REQ-029 cmd_valid while busy SHALL be ignored (no latch, no side effect); the requester holds it until accepted.
REQ-030 rsp_ready low in RSP SHALL stall indefinitely with no register-file access.
REQ-031 rf_rs1_addr SHALL hold the latched addr in all states (no glitching to unrelated registers).

Reset
REQ-032 rst low SHALL immediately force state IDLE, rf_we=0, rsp_valid=0, rsp_last=0, rsp_err=0, rsp_addr=0, rsp_data=0, rf_rd_addr=0, rf_rd_data=0, rf_rs1_addr=0, busy=0.
REQ-033 Reset mid-DUMP or mid-CLEAR SHALL abort with no further writes; registers already cleared stay cleared.
REQ-034 First command SHALL be accepted at the first rising edge after rst returns high.

Verification
REQ-035 WRITE addr=3 data=4'hA, then READ addr=3 -> rf_we pulse 1 cycle at x3; READ response rsp_data=4'hA, rsp_addr=3, rsp_last=1, rsp_err=0, at N+2.
REQ-036 WRITE addr=0 data=4'hF -> rf_we never asserted; rsp_err=1; subsequent READ addr=0 -> rsp_data=0.
REQ-037 Preload x1..x7 = 1..7, DUMP with rsp_ready toggling 1/0 -> 8 responses addr 0..7, data 0,1..7, rsp_last only on addr 7, payload stable while stalled.
REQ-038 Preload x1..x7 = 4'hF, CLEAR -> 7 consecutive rf_we cycles addr 1..7, one response at N+8; DUMP then returns all 0.
REQ-039 cmd_valid held high during busy with differing op -> ignored until IDLE; accepted exactly once.
REQ-040 rst low during DUMP at addr 4 -> all outputs reset value within same cycle; next command after release executes normally.
